// File: rtl/dff_pkg.sv
// dff_pkg: shared default constants and width helpers for the dff_pipe slice
package dff_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    localparam logic DEF_RESET_BIT = 1'b0;
    function automatic int clog2(input int n);
        int r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction
    function automatic int occ_w(input int depth);
        return clog2(depth + 1);
    endfunction
endpackage

// File: rtl/dff_pipe_if.sv
// dff_pipe_if: valid/ready streaming bus plus flush for dff_pipe
interface dff_pipe_if import dff_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] din;
    logic din_vld;
    logic din_rdy;
    logic flush;
    logic [WIDTH-1:0] q;
    logic q_vld;
    logic q_rdy;
    modport master (output din, din_vld, flush, q_rdy, input din_rdy, q, q_vld);
    modport slave (input din, din_vld, flush, q_rdy, output din_rdy, q, q_vld);
endinterface

// File: rtl/dff_stage.sv
// dff_stage: one elastic register stage with valid bit and ready computation
module dff_stage import dff_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{DEF_RESET_BIT}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             up_vld,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_rdy,
    output logic             rdy,
    output logic             vld,
    output logic [WIDTH-1:0] data
);
    logic load;
    always_comb begin
        rdy = !vld || dn_rdy;
        load = up_vld && rdy && !flush;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            data <= RESET_VAL;
        end else begin
            vld <= !flush && (load || (vld && !dn_rdy));
            if (load) data <= up_data;
        end
    end
endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: elastic DEPTH-stage register pipeline; define DFF_PIPE_OCC_EN to add the occ counter port
module dff_pipe import dff_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{DEF_RESET_BIT}}
) (
    input logic clk,
    input logic rst_n,
    dff_pipe_if.slave bus
`ifdef DFF_PIPE_OCC_EN
    ,
    output logic [occ_w(DEPTH)-1:0] occ
`endif
);
    logic [WIDTH-1:0] data [DEPTH];
    logic vld [DEPTH];
    logic rdy [DEPTH+1];
    logic in_fire;
    assign rdy[DEPTH] = bus.q_rdy;
    assign bus.din_rdy = rdy[0] && !bus.flush && rst_n;
    assign in_fire = bus.din_vld && bus.din_rdy;
    assign bus.q = data[DEPTH-1];
    assign bus.q_vld = vld[DEPTH-1];
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic up_vld;
        logic [WIDTH-1:0] up_data;
        if (i == 0) begin : g_head
            assign up_vld = in_fire;
            assign up_data = bus.din;
        end else begin : g_body
            assign up_vld = vld[i-1];
            assign up_data = data[i-1];
        end
        dff_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
            .clk(clk),
            .rst_n(rst_n),
            .flush(bus.flush),
            .up_vld(up_vld),
            .up_data(up_data),
            .dn_rdy(rdy[i+1]),
            .rdy(rdy[i]),
            .vld(vld[i]),
            .data(data[i])
        );
    end
`ifdef DFF_PIPE_OCC_EN
    localparam int OCC_W = $bits(occ);
    logic out_fire;
    assign out_fire = bus.q_vld && bus.q_rdy;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) occ <= '0;
        else occ <= bus.flush ? '0 :
                    (in_fire && !out_fire) ? occ + OCC_W'(1) :
                    (out_fire && !in_fire) ? occ - OCC_W'(1) : occ;
    end
`endif
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed and random checks of dff_pipe against a word-position queue model
module tb_dff_pipe;
    localparam int DEPTH = 4;
    logic clk;
    logic rst_n;
    dff_pipe_if #(.WIDTH(8)) bus ();
`ifdef DFF_PIPE_OCC_EN
    logic [2:0] occ;
`endif
    dff_pipe #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef DFF_PIPE_OCC_EN
        ,
        .occ(occ)
`endif
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_asrt = 0;
    int n_fail = 0;
    // model: words in flight, oldest first, with the stage each occupies
    int pos_q[$];
    logic [7:0] dat_q[$];
    logic [7:0] last_q = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_outputs(input logic f, input logic r);
        logic qv;
        logic rd;
        qv = pos_q.size() > 0 && pos_q[0] == DEPTH - 1;
        rd = !f && (pos_q.size() < DEPTH || r);
        chk("din_rdy", 32'(bus.din_rdy), 32'(rd));
        chk("q_vld", 32'(bus.q_vld), 32'(qv));
        chk("q", 32'(bus.q), 32'(last_q));
`ifdef DFF_PIPE_OCC_EN
        chk("occ", 32'(occ), 32'(pos_q.size()));
`endif
    endtask

    // a word at stage p moves on when q_rdy is high or some stage beyond it is empty
    task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic f);
        int np[$];
        logic [7:0] nd[$];
        logic rd;
        bus.din_vld = v;
        bus.din = d;
        bus.q_rdy = r;
        bus.flush = f;
        #1;
        chk_outputs(f, r);
        rd = !f && (pos_q.size() < DEPTH || r);
        if (!f) begin
            for (int k = 0; k < pos_q.size(); k++) begin
                if (r || k < DEPTH - 1 - pos_q[k]) begin
                    if (pos_q[k] < DEPTH - 1) begin
                        np.push_back(pos_q[k] + 1);
                        nd.push_back(dat_q[k]);
                        if (pos_q[k] + 1 == DEPTH - 1) last_q = dat_q[k];
                    end
                end else begin
                    np.push_back(pos_q[k]);
                    nd.push_back(dat_q[k]);
                end
            end
            if (v && rd) begin
                np.push_back(0);
                nd.push_back(d);
                if (DEPTH == 1) last_q = d;
            end
        end
        @(posedge clk);
        pos_q = np;
        dat_q = nd;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < DEPTH + 2; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.din_vld = 1'b1;
        bus.din = 8'h5A;
        bus.q_rdy = 1'b1;
        bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_q", 32'(bus.q), 32'h00);
        chk("rst_q_vld", 32'(bus.q_vld), 32'h0);
        chk("rst_din_rdy", 32'(bus.din_rdy), 32'h0);
`ifdef DFF_PIPE_OCC_EN
        chk("rst_occ", 32'(occ), 32'h0);
`endif
        rst_n = 1'b1;
        bus.din_vld = 1'b0;
        #1;
        chk("rel_din_rdy", 32'(bus.din_rdy), 32'h1);
        chk("rel_q_vld", 32'(bus.q_vld), 32'h0);
        @(negedge clk);

        for (int k = 1; k <= 16; k++) begin
            cyc(1'b1, 8'(k), 1'b1, 1'b0);
            if (k == DEPTH) begin
                chk("lat_q_vld", 32'(bus.q_vld), 32'h1);
                chk("lat_q", 32'(bus.q), 32'h01);
            end
        end
        drain();

        for (int k = 0; k < 6; k++) cyc(1'b1, 8'hA0 + 8'(k), 1'b0, 1'b0);
        chk("full_din_rdy", 32'(bus.din_rdy), 32'h0);
        cyc(1'b1, 8'hA4, 1'b1, 1'b0);
        cyc(1'b1, 8'hA5, 1'b1, 1'b0);
        drain();

        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("bub_q", 32'(bus.q), 32'h11);
        repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        drain();

        for (int k = 0; k < 3; k++) cyc(1'b1, 8'h30 + 8'(k), 1'b0, 1'b0);
        cyc(1'b1, 8'h77, 1'b0, 1'b1);
        chk("fl_q_vld", 32'(bus.q_vld), 32'h0);
        cyc(1'b1, 8'h88, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fl_q", 32'(bus.q), 32'h88);
        chk("fl_q_vld2", 32'(bus.q_vld), 32'h1);
        drain();

        for (int k = 0; k < 5; k++) cyc(1'b1, 8'hC0 + 8'(k), 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_q_vld", 32'(bus.q_vld), 32'h0);
        chk("ar_q", 32'(bus.q), 32'h00);
        chk("ar_din_rdy", 32'(bus.din_rdy), 32'h0);
`ifdef DFF_PIPE_OCC_EN
        chk("ar_occ", 32'(occ), 32'h0);
`endif
        pos_q.delete();
        dat_q.delete();
        last_q = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        drain();

        for (int k = 0; k < 400; k++)
            cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
